systolic_skew_stream: RTL and testbench
=======================================

Name: systolic_skew_stream

Overview:
Next-generation operand skew unit for the systolic array. Each of LENGTH lanes gets a triangular delay. Skew mode: lane i delayed i steps (array input side). Deskew mode: lane i delayed LENGTH-1-i steps (realigns array results). Adds valid/ready flow control, per-lane valid tracking, and an automatic zero-fill drain after the last vector. The pipeline advances only on handshake steps, never on free-running clocks.

Parameters:
WIDTH, 8, bits per lane element
LENGTH, 16, lane count (>=1); also max delay+1
DESKEW, 0, 0 = lane i delay i; 1 = lane i delay LENGTH-1-i

Ports:
CLK  input  1  clock, rising edge
ASYNC_RST  input  1  asynchronous, active-low reset
SYNC_RST  input  1  synchronous clear, active-high, highest priority after ASYNC_RST
IN_VALID  input  1  input vector valid
IN_READY  output  1  unit accepts input vector
IN_LAST  input  1  qualifies final vector of a stream
IN_DATA  input  WIDTH x LENGTH  unpacked array [0:LENGTH-1] of aligned lane data
OUT_VALID  output  1  output vector valid
OUT_READY  input  1  downstream accepts output vector
OUT_LAST  output  1  final vector of drained stream
OUT_DATA  output  WIDTH x LENGTH  unpacked array [0:LENGTH-1] of skewed/deskewed data
OUT_LANE_VLD  output  LENGTH  bit i = OUT_DATA[i] carries real data, not fill
BUSY  output  1  state != IDLE

Behaviour:
- Delay storage: LENGTH*(LENGTH-1)/2 data regs plus one valid bit per reg. Lane with delay d = chain of d regs. Zero-delay lane is combinational from the lane input.
- Lane input: IN_DATA[i] with valid = 1 in IDLE/STREAM; 0 with valid = 0 in DRAIN.
- step = OUT_VALID & OUT_READY. All chains shift one position on step only; otherwise they hold.
- OUT_DATA[i] = chain tail, or lane input for the zero-delay lane.
- OUT_LANE_VLD[i] = tail valid bit, or lane input valid for the zero-delay lane. It is 0 whenever OUT_VALID = 0.
- States:
  - IDLE: OUT_VALID = IN_VALID; IN_READY = OUT_READY.
  - STREAM: OUT_VALID = IN_VALID; IN_READY = OUT_READY.
  - DRAIN: OUT_VALID = 1; IN_READY = 0.
- Transitions:
  - IDLE/STREAM -> STREAM on step with IN_LAST = 0.
  - IDLE/STREAM -> DRAIN on step with IN_LAST = 1 and LENGTH > 1; drain counter cleared to 0.
  - LENGTH == 1: IN_LAST step stays IDLE and OUT_LAST = IN_LAST combinationally.
  - DRAIN: counter increments each step. At counter == LENGTH-2, OUT_LAST = 1; that step returns to IDLE.
  - Drain length is exactly LENGTH-1 steps.
- Counter width $clog2(LENGTH), minimum 1. It wraps only via the return to IDLE.
- OUT_LAST = 0 in IDLE/STREAM for LENGTH > 1.
- Bubbles (IN_VALID = 0 in STREAM): no step, chains hold, OUT_VALID = 0.
- Backpressure (OUT_READY = 0): no step; all regs, state and counter hold; outputs stable.
- Reset values: all data regs 0, valid bits 0, state IDLE, counter 0. Resulting outputs: OUT_VALID = 0, OUT_LAST = 0, OUT_LANE_VLD = 0, BUSY = 0, IN_READY = OUT_READY.
  - OUT_DATA of delayed lanes = 0.
  - OUT_DATA of the zero-delay lane = IN_DATA of that lane; it is combinational and only meaningful with OUT_VALID.
- ASYNC_RST low: immediate reset as above.
- SYNC_RST high at an edge: same reset, overriding step, including mid-drain or mid-stream.

Decomposition:
- Package systolic_pkg:
  - state enum skew_state_e {IDLE, STREAM, DRAIN}
  - function lane_delay(i, LENGTH, DESKEW)
  - function tri_base(d) = d*(d-1)/2 for flat storage indexing
- Sub-module skew_lane_delay #(WIDTH, DEPTH): one lane shift chain with valid bit, shift on step, sync/async clear; DEPTH = 0 is a pass-through.
- Top holds the FSM, drain counter, handshake, and a generate loop of LENGTH lanes.

Test Plan:
- Setup for all scenarios: WIDTH = 8, LENGTH = 4.
- Skew, OUT_READY = 1: V0 = {1,2,3,4} then V1 = {5,6,7,8} with IN_LAST.
  - Steps -> {1,0,0,0} vld 1000; {5,2,0,0} 1100; {0,6,3,0} 0110; {0,0,7,4} 0011; {0,0,0,8} 0001 with OUT_LAST.
  - Then IDLE, BUSY = 0.
- Backpressure: same stimulus with OUT_READY = 0 for 3 cycles at step 2 -> OUT_DATA/OUT_LANE_VLD hold {0,6,3,0}/0110, IN_READY = 0, counter unchanged; resume yields the identical sequence.
- DESKEW = 1: feed five full vectors {1,0,0,0},{5,2,0,0},{0,6,3,0},{0,0,7,4},{0,0,0,8} (last with IN_LAST).
  - Step 3 -> {1,2,3,4}; step 4 -> {5,6,7,8}.
  - OUT_LAST on step 7 (after 3 drain steps).
- Bubbles: IN_VALID toggles 1,0,0,1 with V0, V1 -> OUT_VALID 1,0,0,1 and a sequence identical to scenario 1.
- SYNC_RST high during drain step 1 -> next cycle state IDLE, OUT_LANE_VLD = 0000, delayed lanes 0; a new V0 = {9,9,9,9} then gives {9,0,0,0}.
- ASYNC_RST low mid-stream between clock edges -> OUT_VALID = 0, BUSY = 0 immediately; after release, scenario 1 reproduces exactly.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic operand skew unit.
// Lane delays form a triangle; tri_base gives the flat offset of a d-deep chain.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skew_state_e;

  function automatic int lane_delay(input int i, input int length, input bit deskew);
    return deskew ? (length - 1 - i) : i;
  endfunction

  function automatic int tri_base(input int d);
    return (d * (d - 1)) / 2;
  endfunction

endpackage

// File: rtl/skew_lane_delay.sv
// One lane of the skew triangle: a DEPTH-deep data/valid shift chain that
// advances only on step. DEPTH = 0 degenerates to a combinational pass-through.
module skew_lane_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 0
) (
  input  logic             CLK,
  input  logic             ASYNC_RST,
  input  logic             SYNC_RST,
  input  logic             step,
  input  logic [WIDTH-1:0] lane_data,
  input  logic             lane_vld,
  output logic [WIDTH-1:0] tail_data,
  output logic             tail_vld
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = ^{CLK, ASYNC_RST, SYNC_RST, step};
      assign tail_data   = lane_data;
      assign tail_vld    = lane_vld;
    end else begin : g_chain
      logic [WIDTH-1:0] data_q [DEPTH];
      logic [DEPTH-1:0] vld_q;

      always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
          for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
          vld_q <= '0;
        end else if (SYNC_RST) begin
          for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
          vld_q <= '0;
        end else if (step) begin
          data_q[0] <= lane_data;
          vld_q[0]  <= lane_vld;
          for (int k = 1; k < DEPTH; k++) begin
            data_q[k] <= data_q[k-1];
            vld_q[k]  <= vld_q[k-1];
          end
        end
      end

      assign tail_data = data_q[DEPTH-1];
      assign tail_vld  = vld_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_skew_stream.sv
// Triangular skew/deskew stage with valid/ready flow control and an
// automatic zero-fill drain of LENGTH-1 steps after the last vector.
module systolic_skew_stream
  import systolic_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 16,
  parameter int DESKEW = 0
) (
  input  logic              CLK,
  input  logic              ASYNC_RST,
  input  logic              SYNC_RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              IN_LAST,
  input  logic [WIDTH-1:0]  IN_DATA [0:LENGTH-1],
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic [WIDTH-1:0]  OUT_DATA [0:LENGTH-1],
  output logic [LENGTH-1:0] OUT_LANE_VLD,
  output logic              BUSY
);

  localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((LENGTH > 1) ? (LENGTH - 2) : 0);

  skew_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             draining;
  logic             step;

  assign draining = (state_q == DRAIN);

  // Handshake: drain ignores upstream and pushes zero-fill until the triangle empties.
  always_comb begin
    OUT_VALID = IN_VALID;
    IN_READY  = OUT_READY;
    if (draining) begin
      OUT_VALID = 1'b1;
      IN_READY  = 1'b0;
    end
    step = OUT_VALID & OUT_READY;
    BUSY = (state_q != IDLE);
    if (LENGTH == 1) OUT_LAST = IN_LAST;
    else             OUT_LAST = draining && (cnt_q == LAST_CNT);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (step) begin
      case (state_q)
        IDLE, STREAM: begin
          if (IN_LAST) begin
            state_d = (LENGTH > 1) ? DRAIN : IDLE;
            cnt_d   = '0;
          end else begin
            state_d = STREAM;
          end
        end
        DRAIN: begin
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (SYNC_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar i = 0; i < LENGTH; i++) begin : g_lane
    localparam int DLY = lane_delay(i, LENGTH, DESKEW != 0);
    logic [WIDTH-1:0] lane_data;
    logic [WIDTH-1:0] tail_data;
    logic             tail_vld;

    assign lane_data = draining ? '0 : IN_DATA[i];

    skew_lane_delay #(
      .WIDTH (WIDTH),
      .DEPTH (DLY)
    ) u_lane (
      .CLK       (CLK),
      .ASYNC_RST (ASYNC_RST),
      .SYNC_RST  (SYNC_RST),
      .step      (step),
      .lane_data (lane_data),
      .lane_vld  (!draining),
      .tail_data (tail_data),
      .tail_vld  (tail_vld)
    );

    assign OUT_DATA[i]     = tail_data;
    assign OUT_LANE_VLD[i] = tail_vld & OUT_VALID;
  end

endmodule

// File: tb/tb_systolic_skew_stream.sv
// Directed bench for systolic_skew_stream: one skew and one deskew instance
// (WIDTH 8, LENGTH 4) sharing stimulus; only the instance under test is checked.
module tb_systolic_skew_stream;

  localparam logic [31:0] V0 = 32'h01020304;
  localparam logic [31:0] V1 = 32'h05060708;

  logic       clk = 1'b0;
  logic       async_rst = 1'b0;
  logic       sync_rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_data [0:3];

  logic       s_in_ready, s_out_valid, s_out_last, s_busy;
  logic [7:0] s_out_data [0:3];
  logic [3:0] s_lane_vld;
  logic       d_in_ready, d_out_valid, d_out_last, d_busy;
  logic [7:0] d_out_data [0:3];
  logic [3:0] d_lane_vld;

  // Snapshots read lane 0 first so expectations match the written vectors.
  logic [37:0] s_snap, d_snap;
  assign s_snap = {s_out_valid, s_out_last,
                   s_lane_vld[0], s_lane_vld[1], s_lane_vld[2], s_lane_vld[3],
                   s_out_data[0], s_out_data[1], s_out_data[2], s_out_data[3]};
  assign d_snap = {d_out_valid, d_out_last,
                   d_lane_vld[0], d_lane_vld[1], d_lane_vld[2], d_lane_vld[3],
                   d_out_data[0], d_out_data[1], d_out_data[2], d_out_data[3]};

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_skew_data [5] = '{32'h01000000, 32'h05020000, 32'h00060300,
                                     32'h00000704, 32'h00000008};
  logic [3:0]  exp_skew_vld  [5] = '{4'b1000, 4'b1100, 4'b0110, 4'b0011, 4'b0001};

  always #5 clk = ~clk;

  systolic_skew_stream #(.WIDTH(8), .LENGTH(4), .DESKEW(0)) dut_skew (
    .CLK(clk), .ASYNC_RST(async_rst), .SYNC_RST(sync_rst),
    .IN_VALID(in_valid), .IN_READY(s_in_ready), .IN_LAST(in_last), .IN_DATA(in_data),
    .OUT_VALID(s_out_valid), .OUT_READY(out_ready), .OUT_LAST(s_out_last),
    .OUT_DATA(s_out_data), .OUT_LANE_VLD(s_lane_vld), .BUSY(s_busy)
  );

  systolic_skew_stream #(.WIDTH(8), .LENGTH(4), .DESKEW(1)) dut_deskew (
    .CLK(clk), .ASYNC_RST(async_rst), .SYNC_RST(sync_rst),
    .IN_VALID(in_valid), .IN_READY(d_in_ready), .IN_LAST(in_last), .IN_DATA(in_data),
    .OUT_VALID(d_out_valid), .OUT_READY(out_ready), .OUT_LAST(d_out_last),
    .OUT_DATA(d_out_data), .OUT_LANE_VLD(d_lane_vld), .BUSY(d_busy)
  );

  task automatic drive(input logic v, input logic last, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    in_valid  = v;
    in_last   = last;
    out_ready = rdy;
    for (int i = 0; i < 4; i++) in_data[i] = d[31-8*i -: 8];
    #1;
  endtask

  task automatic sync_clear();
    @(negedge clk);
    sync_rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    sync_rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) in_data[i] = 8'h00;
    #3;
    checks++;
    if (s_snap !== 38'h0) begin
      errors++; $display("[TB] FAIL reset_skew_outputs: got %h want %h", s_snap, 38'h0);
    end
    checks++;
    if (d_snap !== 38'h0) begin
      errors++; $display("[TB] FAIL reset_deskew_outputs: got %h want %h", d_snap, 38'h0);
    end
    checks++;
    if (s_busy !== 1'b0 || s_in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_busy_ready: got %b%b want 01", s_busy, s_in_ready);
    end
    out_ready = 1'b0;
    #1;
    checks++;
    if (s_in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready_follows: got %b want 0", s_in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #2 async_rst = 1'b1;
  endtask

  task automatic test_skew_stream(input string tag);
    for (int k = 0; k < 5; k++) begin
      if (k == 0)      drive(1'b1, 1'b0, V0, 1'b1);
      else if (k == 1) drive(1'b1, 1'b1, V1, 1'b1);
      else             drive(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (s_snap !== {1'b1, 1'(k == 4), exp_skew_vld[k], exp_skew_data[k]}) begin
        errors++;
        $display("[TB] FAIL %s step %0d: got %h want %h", tag, k, s_snap,
                 {1'b1, 1'(k == 4), exp_skew_vld[k], exp_skew_data[k]});
      end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (s_busy !== 1'b0 || s_snap !== 38'h0) begin
      errors++; $display("[TB] FAIL %s idle_after: busy %b snap %h want 0 / 0", tag, s_busy, s_snap);
    end
  endtask

  task automatic test_backpressure();
    sync_clear();
    drive(1'b1, 1'b0, V0, 1'b1);
    drive(1'b1, 1'b1, V1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (s_snap !== {2'b10, 4'b0110, 32'h00060300} || s_in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL backpressure_hold cycle %0d: got %h rdy %b want %h rdy 0", c, s_snap,
                 s_in_ready, {2'b10, 4'b0110, 32'h00060300});
      end
    end
    for (int k = 2; k < 5; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (s_snap !== {1'b1, 1'(k == 4), exp_skew_vld[k], exp_skew_data[k]}) begin
        errors++;
        $display("[TB] FAIL backpressure_resume step %0d: got %h want %h", k, s_snap,
                 {1'b1, 1'(k == 4), exp_skew_vld[k], exp_skew_data[k]});
      end
    end
  endtask

  task automatic test_deskew();
    logic [31:0] stim [8] = '{32'h01000000, 32'h05020000, 32'h00060300, 32'h00000704,
                              32'h00000008, 32'h0, 32'h0, 32'h0};
    logic [37:0] exp  [8] = '{{2'b10, 4'b0001, 32'h0}, {2'b10, 4'b0011, 32'h0},
                              {2'b10, 4'b0111, 32'h0}, {2'b10, 4'b1111, 32'h01020304},
                              {2'b10, 4'b1111, 32'h05060708}, {2'b10, 4'b1110, 32'h0},
                              {2'b10, 4'b1100, 32'h0}, {2'b11, 4'b1000, 32'h0}};
    sync_clear();
    for (int k = 0; k < 8; k++) begin
      drive(1'(k < 5), 1'(k == 4), stim[k], 1'b1);
      checks++;
      if (d_snap !== exp[k]) begin
        errors++; $display("[TB] FAIL deskew step %0d: got %h want %h", k, d_snap, exp[k]);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (d_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL deskew_idle_after: busy %b want 0", d_busy);
    end
  endtask

  task automatic test_bubbles();
    sync_clear();
    drive(1'b1, 1'b0, V0, 1'b1);
    checks++;
    if (s_snap !== {2'b10, exp_skew_vld[0], exp_skew_data[0]}) begin
      errors++; $display("[TB] FAIL bubbles step 0: got %h want %h", s_snap,
                         {2'b10, exp_skew_vld[0], exp_skew_data[0]});
    end
    for (int b = 0; b < 2; b++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (s_snap !== {2'b00, 4'b0000, 32'h00020000} || s_busy !== 1'b1) begin
        errors++; $display("[TB] FAIL bubble_hold %0d: got %h busy %b want %h busy 1", b, s_snap,
                           s_busy, {2'b00, 4'b0000, 32'h00020000});
      end
    end
    for (int k = 1; k < 5; k++) begin
      if (k == 1) drive(1'b1, 1'b1, V1, 1'b1);
      else        drive(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (s_snap !== {1'b1, 1'(k == 4), exp_skew_vld[k], exp_skew_data[k]}) begin
        errors++; $display("[TB] FAIL bubbles step %0d: got %h want %h", k, s_snap,
                           {1'b1, 1'(k == 4), exp_skew_vld[k], exp_skew_data[k]});
      end
    end
  endtask

  task automatic test_sync_reset();
    sync_clear();
    drive(1'b1, 1'b0, V0, 1'b1);
    drive(1'b1, 1'b1, V1, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    sync_rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    sync_rst = 1'b0;
    checks++;
    if (s_snap !== 38'h0 || s_busy !== 1'b0 || s_in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL sync_reset_clear: snap %h busy %b rdy %b want 0 / 0 / 1",
                         s_snap, s_busy, s_in_ready);
    end
    drive(1'b1, 1'b0, 32'h09090909, 1'b1);
    checks++;
    if (s_snap !== {2'b10, 4'b1000, 32'h09000000}) begin
      errors++; $display("[TB] FAIL sync_reset_restart: got %h want %h", s_snap,
                         {2'b10, 4'b1000, 32'h09000000});
    end
    drive(1'b1, 1'b1, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_async_reset();
    sync_clear();
    drive(1'b1, 1'b0, V0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (s_busy !== 1'b1) begin
      errors++; $display("[TB] FAIL async_pre_busy: got %b want 1", s_busy);
    end
    #2 async_rst = 1'b0;
    #1;
    checks++;
    if (s_busy !== 1'b0 || s_snap !== 38'h0) begin
      errors++; $display("[TB] FAIL async_reset_immediate: busy %b snap %h want 0 / 0", s_busy, s_snap);
    end
    #1 async_rst = 1'b1;
    test_skew_stream("async_rerun");
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_skew_stream("skew");
    test_backpressure();
    test_deskew();
    test_bubbles();
    test_sync_reset();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
